// File: rtl/seg7_bcd_display_ctrl.sv
// seg7_bcd_display_ctrl
//
// Multi-digit seven-segment display controller. A binary value, optionally
// two's complement, is converted to BCD by a sequential double-dabble engine
// (one bit per clock). The result drives DIGITS numeric displays. The
// controller also drives one letter display that is independent of the
// conversion.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   load        start a conversion; sampled only in IDLE
//   num         binary value, captured on an accepted load
//   is_signed   treat num as two's complement; captured with num
//   letter      letter-display code, registered every cycle
//   segs        numeric digits, digit k at [7k+6:7k], k=0 rightmost, bit0=a..bit6=g
//   seg_letter  letter display, same segment encoding
//   busy        high while the BCD engine is shifting
//   done        one-cycle pulse when segs/overflow have been updated
//   overflow    last conversion did not fit the display; held until next done
//   dbg_state_o current controller state (IDLE=0, CONV=1, UPDATE=2)
//
// Handshake: load is a request that is accepted only on a rising edge where
// the controller is IDLE. busy is high from the edge after acceptance until
// the result is ready. done pulses for one cycle when segs is valid. A load
// that arrives while busy or in UPDATE is dropped and is not queued.

module seg7_bcd_display_ctrl #(
    parameter int NUM_W          = 8,
    parameter int DIGITS         = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [NUM_W-1:0]      num,
    input  logic                  is_signed,
    input  logic [3:0]            letter,
    output logic [7*DIGITS-1:0]   segs,
    output logic [6:0]            seg_letter,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    localparam int          BCD_DIG = DIGITS + 2;
    localparam int          BCD_W   = 4 * BCD_DIG;
    localparam int          CNT_W   = $clog2(NUM_W + 1);
    localparam logic [31:0] POS_MAX = 32'(pow10(DIGITS) - 1);
    localparam logic [31:0] NEG_MAX = 32'(pow10(DIGITS - 1) - 1);
    localparam logic [6:0]  BLANK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0]  GLYPH_MINUS = 7'h40;

    // Active-high glyphs, bit6=g .. bit0=a
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] letter_glyph(input logic [3:0] c);
        case (c)
            4'd0:    return 7'h77; // A
            4'd1:    return 7'h7C; // b
            4'd2:    return 7'h39; // C
            4'd3:    return 7'h5E; // d
            4'd4:    return 7'h79; // E
            4'd5:    return 7'h71; // F
            4'd6:    return 7'h76; // H
            4'd7:    return 7'h38; // L
            4'd8:    return 7'h73; // P
            4'd9:    return 7'h50; // r
            4'd10:   return 7'h3E; // U
            4'd11:   return 7'h54; // n
            4'd12:   return 7'h5C; // o
            4'd13:   return 7'h78; // t
            4'd14:   return 7'h40; // -
            default: return 7'h00; // blank
        endcase
    endfunction

    function automatic logic [6:0] polarity(input logic [6:0] g);
        return (SEG_ACTIVE_LOW != 0) ? ~g : g;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_W-1:0]     mag_q, mag_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 neg_q, neg_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [7*DIGITS-1:0]  segs_q, segs_d;
    logic [6:0]           seg_letter_q;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;

    // Capture path. The magnitude is formed one bit wider than num so that
    // the most negative value negates correctly; its low NUM_W bits always
    // hold the magnitude because a negative magnitude never exceeds 2^(NUM_W-1).
    logic                 neg_c;
    logic [NUM_W:0]       mag_c;
    logic [31:0]          mag_ext;
    logic                 ovf_c;

    always_comb begin
        neg_c   = is_signed & num[NUM_W-1];
        mag_c   = neg_c ? ((NUM_W+1)'(0) - {num[NUM_W-1], num}) : {1'b0, num};
        mag_ext = 32'(mag_c);
        // Negative values lose one digit position to the minus sign.
        ovf_c   = neg_c ? (mag_ext > NEG_MAX) : (mag_ext > POS_MAX);
    end

    // Double-dabble step: correct nibbles >= 5 before shifting so each one
    // carries correctly into the next decade.
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_shift;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[NUM_W-1]};
    end

    // Display composition from the finished BCD value.
    int                   msd;
    int                   minus_pos;
    logic [6:0]           glyph;
    logic [7*DIGITS-1:0]  disp_c;

    always_comb begin
        msd = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) msd = k;
        end
        minus_pos = (BLANK_LEADING != 0) ? (msd + 1) : (DIGITS - 1);
        disp_c    = '0;
        glyph     = 7'h00;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_pend_q)
                glyph = GLYPH_MINUS;
            else if (neg_q && (k == minus_pos))
                glyph = GLYPH_MINUS;
            else if ((BLANK_LEADING == 0) || (k <= msd))
                glyph = digit_glyph(bcd_q[4*k +: 4]);
            else
                glyph = 7'h00;
            disp_c[7*k +: 7] = polarity(glyph);
        end
    end

    // Controller next state and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ovf_pend_d = ovf_pend_q;
        segs_d     = segs_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d    = S_CONV;
                    mag_d      = mag_c[NUM_W-1:0];
                    neg_d      = neg_c;
                    ovf_pend_d = ovf_c;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(NUM_W);
                end
            end
            S_CONV: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[NUM_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                segs_d     = disp_c;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mag_q        <= '0;
            bcd_q        <= '0;
            neg_q        <= 1'b0;
            ovf_pend_q   <= 1'b0;
            segs_q       <= {DIGITS{BLANK}};
            seg_letter_q <= BLANK;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            neg_q        <= neg_d;
            ovf_pend_q   <= ovf_pend_d;
            segs_q       <= segs_d;
            seg_letter_q <= polarity(letter_glyph(letter));
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign segs        = segs_q;
    assign seg_letter  = seg_letter_q;
    assign busy        = (state_q == S_CONV);
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg7_bcd_display_ctrl.sv
// Testbench for seg7_bcd_display_ctrl: three instances (default, DIGITS=2,
// BLANK_LEADING=0) driven by directed vectors with hand-computed glyphs.
// Drivers push expected results into per-instance queues and monitors pop
// them on each done pulse.

module tb_seg7_bcd_display_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       load_a, load_b, load_c;
    logic [7:0] num;
    logic       is_signed;
    logic [3:0] letter;

    logic [27:0] segs_a;  logic [6:0] sl_a; logic busy_a, done_a, ovf_a; logic [1:0] st_a;
    logic [13:0] segs_b;  logic [6:0] sl_b; logic busy_b, done_b, ovf_b; logic [1:0] st_b;
    logic [27:0] segs_c;  logic [6:0] sl_c; logic busy_c, done_c, ovf_c; logic [1:0] st_c;

    seg7_bcd_display_ctrl #(.NUM_W(8), .DIGITS(4), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .reset(rst_n), .load(load_a), .num(num), .is_signed(is_signed),
        .letter(letter), .segs(segs_a), .seg_letter(sl_a), .busy(busy_a), .done(done_a),
        .overflow(ovf_a), .dbg_state_o(st_a));

    seg7_bcd_display_ctrl #(.NUM_W(8), .DIGITS(2), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_b (
        .clk(clk), .reset(rst_n), .load(load_b), .num(num), .is_signed(is_signed),
        .letter(letter), .segs(segs_b), .seg_letter(sl_b), .busy(busy_b), .done(done_b),
        .overflow(ovf_b), .dbg_state_o(st_b));

    seg7_bcd_display_ctrl #(.NUM_W(8), .DIGITS(4), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(0)) dut_c (
        .clk(clk), .reset(rst_n), .load(load_c), .num(num), .is_signed(is_signed),
        .letter(letter), .segs(segs_c), .seg_letter(sl_c), .busy(busy_c), .done(done_c),
        .overflow(ovf_c), .dbg_state_o(st_c));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // element = {overflow, segs[27:0]}
    logic [28:0] exp_a_q[$];
    logic [28:0] exp_b_q[$];
    logic [28:0] exp_c_q[$];
    logic [28:0] e_a, e_b, e_c;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (done_a) begin
            if (exp_a_q.size() == 0) check("unexpected_done_a", 32'(done_a), 32'd0);
            else begin
                e_a = exp_a_q.pop_front();
                check("segs_a", 32'(segs_a), 32'(e_a[27:0]));
                check("ovf_a", 32'(ovf_a), 32'(e_a[28]));
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (exp_b_q.size() == 0) check("unexpected_done_b", 32'(done_b), 32'd0);
            else begin
                e_b = exp_b_q.pop_front();
                check("segs_b", 32'(segs_b), 32'(e_b[13:0]));
                check("ovf_b", 32'(ovf_b), 32'(e_b[28]));
            end
        end
    end

    always @(negedge clk) begin
        if (done_c) begin
            if (exp_c_q.size() == 0) check("unexpected_done_c", 32'(done_c), 32'd0);
            else begin
                e_c = exp_c_q.pop_front();
                check("segs_c", 32'(segs_c), 32'(e_c[27:0]));
                check("ovf_c", 32'(ovf_c), 32'(e_c[28]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic done_of(input int sel);
        return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    endfunction

    task automatic set_load(input int sel, input logic v);
        if (sel == 0) load_a = v;
        else if (sel == 1) load_b = v;
        else load_c = v;
    endtask

    task automatic push_exp(input int sel, input logic [27:0] s, input logic o);
        if (sel == 0) exp_a_q.push_back({o, s});
        else if (sel == 1) exp_b_q.push_back({o, s});
        else exp_c_q.push_back({o, s});
    endtask

    // One full conversion; expects done exactly 9 edges after acceptance.
    task automatic run_conv(input int sel, input logic [7:0] n, input logic sg,
                            input logic [27:0] exp_segs, input logic exp_ovf);
        int lat;
        push_exp(sel, exp_segs, exp_ovf);
        @(negedge clk);
        num = n; is_signed = sg; set_load(sel, 1'b1);
        @(posedge clk); #1;
        set_load(sel, 1'b0);
        check("busy_after_load", 32'(busy_of(sel)), 32'd1);
        lat = 0;
        while (!done_of(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_latency", 32'(lat), 32'd9);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int lat2;
    logic [3:0]  let_codes [4] = '{4'd0, 4'd9, 4'd13, 4'd14};
    logic [6:0]  let_exp   [4] = '{7'h08, 7'h2F, 7'h07, 7'h3F};

    initial begin
        rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        num = 8'd0; is_signed = 1'b0; letter = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_segs_a", 32'(segs_a), 32'h0FFFFFFF);
        check("rst_segs_b", 32'(segs_b), 32'h00003FFF);
        check("rst_seg_letter", 32'(sl_a), 32'h7F);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_state", 32'(st_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // default instance: 4 digits, leading blanking
        run_conv(0, 8'd4,   1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h19}, 1'b0);
        run_conv(0, 8'hFF,  1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h79}, 1'b0);
        run_conv(0, 8'h80,  1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}, 1'b0);
        run_conv(0, 8'd255, 1'b0, {7'h7F, 7'h24, 7'h12, 7'h12}, 1'b0);
        run_conv(0, 8'd0,   1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);
        run_conv(0, 8'h9C,  1'b1, {7'h3F, 7'h79, 7'h40, 7'h40}, 1'b0);

        // two-digit instance: overflow boundaries
        run_conv(1, 8'd100, 1'b0, {14'h0, 7'h3F, 7'h3F}, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("ovf_b_held", 32'(ovf_b), 32'd1);
        run_conv(1, 8'd7,   1'b0, {14'h0, 7'h7F, 7'h78}, 1'b0);
        run_conv(1, 8'hF7,  1'b1, {14'h0, 7'h3F, 7'h10}, 1'b0);
        run_conv(1, 8'hF6,  1'b1, {14'h0, 7'h3F, 7'h3F}, 1'b1);

        // no blanking instance
        run_conv(2, 8'd0,   1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
        run_conv(2, 8'hFF,  1'b1, {7'h3F, 7'h40, 7'h40, 7'h79}, 1'b0);
        run_conv(2, 8'd123, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30}, 1'b0);

        // load during CONV is dropped; only one done for the first value
        push_exp(0, {7'h7F, 7'h7F, 7'h30, 7'h78}, 1'b0);
        @(negedge clk); num = 8'd37; is_signed = 1'b0; load_a = 1'b1;
        @(posedge clk); #1 load_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); num = 8'd9; load_a = 1'b1;
        @(negedge clk); load_a = 1'b0;
        lat2 = 4;
        while (!done_a && lat2 < 40) begin
            @(posedge clk); #1;
            lat2++;
        end
        check("done_latency_midload", 32'(lat2), 32'd9);
        repeat (20) @(posedge clk);

        // letter display during CONV, then reset mid-conversion
        @(negedge clk); num = 8'd200; load_a = 1'b1;
        @(posedge clk); #1 load_a = 1'b0; letter = 4'd6;
        @(posedge clk); #1;
        check("letter_H_in_conv", 32'(sl_a), 32'h09);
        check("busy_in_conv", 32'(busy_a), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_segs_a", 32'(segs_a), 32'h0FFFFFFF);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_ovf_b", 32'(ovf_b), 32'd0);
        check("midrst_letter", 32'(sl_a), 32'h7F);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("letter_after_rst", 32'(sl_a), 32'h09);
        repeat (20) @(posedge clk);
        #1 check("segs_a_still_blank", 32'(segs_a), 32'h0FFFFFFF);

        // letter table sample
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); letter = let_codes[i];
            @(posedge clk); #1;
            check("letter_glyph", 32'(sl_b), 32'(let_exp[i]));
        end

        // overflow cleared by next good conversion after reset
        run_conv(1, 8'd99, 1'b0, {14'h0, 7'h10, 7'h10}, 1'b0);

        repeat (5) @(posedge clk);
        check("queue_a_empty", 32'(exp_a_q.size()), 32'd0);
        check("queue_b_empty", 32'(exp_b_q.size()), 32'd0);
        check("queue_c_empty", 32'(exp_c_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_bcd_display_ctrl.md
Name: seg7_bcd_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller, the successor to the fixed five-display driver. Converts a binary value, optionally two's-complement signed, to BCD with a sequential double-dabble engine (one bit per clock) and drives DIGITS numeric displays plus one letter display. Adds leading-zero blanking, minus sign, overflow indication and a load/busy/done handshake. Sits between the processor's memory-mapped I/O and the board displays.

Parameters:
NUM_W, 8, width of binary input value (2..20)
DIGITS, 4, number of numeric seven-segment digits (1..6)
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (board default), 0 = active-high
BLANK_LEADING, 1, 1 = blank leading zeros, 0 = show them

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  start conversion; sampled only in IDLE
num  in  NUM_W  binary value, captured on accepted load
is_signed  in  1  treat num as two's complement; captured with num
letter  in  4  letter-display code, registered every cycle independent of conversion
segs  out  7*DIGITS  numeric digits; digit k at bits [7k+6:7k], k=0 rightmost; bit0=a … bit6=g
seg_letter  out  7  letter display, same encoding
busy  out  1  high during CONV
done  out  1  one-cycle pulse when segs updated
overflow  out  1  last conversion did not fit; held until next done

Behaviour:
- Reset (async, reset=0): state IDLE, busy=0, done=0, overflow=0, every segs digit and seg_letter blank (all segments off: 7'h7F active-low, 7'h00 active-high). Deassertion takes effect at next clk edge.
- States: IDLE -> CONV on load=1; CONV -> UPDATE after NUM_W shift cycles; UPDATE -> IDLE unconditionally.
- Capture (IDLE & load): if is_signed & num[NUM_W-1], magnitude = -num (NUM_W+1 bits, so min negative handled), neg=1; else magnitude = num, neg=0. BCD register cleared, bit counter = NUM_W.
- CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, magnitude} left by one; counter decrements. Internal BCD width = 4*(DIGITS+2) bits so no intermediate loss.
- UPDATE: segs, overflow registered, done=1 for this cycle only. Latency: load accepted at edge t -> done high and segs valid after edge t+NUM_W+1.
- Fit limits: unsigned/positive needs magnitude <= 10^DIGITS-1; negative needs magnitude <= 10^(DIGITS-1)-1 (one digit reserved for '-'). Otherwise overflow=1 and all DIGITS digits show '-' (g only).
- Blanking (BLANK_LEADING=1): zeros left of the most significant non-zero digit blank; value 0 shows single '0' in digit 0. '-' placed in digit immediately left of the most significant shown digit. BLANK_LEADING=0: all digits shown, '-' in leftmost digit.
- Digit glyphs (active-high g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, '-'=40, blank=00. SEG_ACTIVE_LOW inverts all outputs.
- Letter codes 0..15: A b C d E F H L P r U n o t '-' blank. seg_letter registered one cycle after letter changes, unaffected by busy.
- load while busy or in UPDATE: ignored, no queueing. segs hold previous value throughout CONV.
- reset asserted mid-conversion: immediate return to reset state; no done pulse.

Test Plan:
- Reset then idle: segs all 7'h7F per digit, seg_letter 7'h7F, busy=0, done=0, overflow=0.
- Default params, load num=8'd4 unsigned at edge t -> busy t+1..t+8, done at t+9; digit0=7'h19, digits 1..3 = 7'h7F, overflow=0.
- num=8'hFF, is_signed=1 -> digit0 '1' (7'h79), digit1 '-' (7'h3F), digits 2,3 blank; num=8'h80 signed -> "-128" (digit3 7'h3F, digits 7'h79,7'h24,7'h00).
- DIGITS=2, num=8'd100 unsigned -> both digits 7'h3F, overflow=1; following load num=8'd7 -> overflow=0, digit0 7'h78.
- Second load pulsed mid-CONV with num=8'd9 -> ignored; result shows first value, exactly one done pulse; num=0 with BLANK_LEADING=0 -> "0000".
- reset pulled low at CONV cycle 4 -> segs blank, busy=0, no done; letter=4'd6 -> seg_letter 7'h09 (H) one cycle later, also during CONV.
